// File: rtl/eth_speed_pkg.sv
// Shared encodings for the RGMII link-speed detector.
package eth_speed_pkg;

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10
  } speed_e;

  typedef enum logic [1:0] {
    NO_LINK = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10
  } state_e;

endpackage

// File: rtl/eth_link_speed_detect_sync.sv
// Brings the rx-clock-derived toggle into the gtx domain and flags each transition.
module sync_toggle_edge #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/eth_link_speed_detect.sv
// Classifies the PHY receive clock as 10M/100M/1000M by counting toggle edges
// against a reference window, with hysteresis and link-loss detection.
module eth_link_speed_detect
  import eth_speed_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int REF_CNT_W      = 7,
  parameter int EDGE_CNT_W     = 2,
  parameter int THRESH_100M    = 32,
  parameter int HYST           = 2,
  parameter int NOLINK_WINDOWS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_toggle,
  input  logic       enable,
  output logic [1:0] speed,
  output logic       mii_select,
  output logic       speed_valid,
  output logic       link_up,
  output logic       speed_change
);

  localparam int MATCH_W = $clog2(HYST + 1);
  localparam int SIL_W   = $clog2(NOLINK_WINDOWS + 1);

  logic                  edge_det;
  logic [REF_CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [SIL_W-1:0]      sil_q, sil_d;
  logic [MATCH_W-1:0]    match_q, match_d, match_inc;
  speed_e                pend_q, pend_d, speed_q, speed_d, cand;
  state_e                state_q, state_d;
  logic                  mii_q, mii_d, valid_q, valid_d, link_q, link_d, chg_q, chg_d;
  logic                  edge_ov, ref_ov, term, silent;

  sync_toggle_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .tog_i (rx_toggle),
    .edge_o(edge_det)
  );

  // Edge overflow takes priority, so a window that fills both counters at once is fast.
  assign edge_ov = &edge_cnt_q;
  assign ref_ov  = &ref_cnt_q;
  assign term    = edge_ov | ref_ov;
  assign silent  = (sil_q == SIL_W'(NOLINK_WINDOWS));
  assign cand    = edge_ov ? ((ref_cnt_q >= REF_CNT_W'(THRESH_100M)) ? SPEED_100M : SPEED_1000M)
                           : SPEED_10M;
  assign match_inc = (cand == pend_q) ? match_q + MATCH_W'(1) : MATCH_W'(1);

  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sil_d      = sil_q;
    match_d    = match_q;
    pend_d     = pend_q;
    state_d    = state_q;
    speed_d    = speed_q;
    mii_d      = mii_q;
    valid_d    = valid_q;
    link_d     = link_q;
    chg_d      = 1'b0;
    if (!enable) begin
      ref_cnt_d  = '0;
      edge_cnt_d = '0;
      sil_d      = '0;
      match_d    = '0;
    end else begin
      if (term) begin
        ref_cnt_d  = '0;
        edge_cnt_d = '0;
      end else begin
        ref_cnt_d  = ref_cnt_q + REF_CNT_W'(1);
        edge_cnt_d = edge_cnt_q + EDGE_CNT_W'(edge_det);
      end
      if (edge_det)
        sil_d = '0;
      else if (ref_ov && edge_cnt_q == '0 && !silent)
        sil_d = sil_q + SIL_W'(1);

      case (state_q)
        NO_LINK: begin
          if (edge_det) begin
            state_d = ACQUIRE;
            link_d  = 1'b1;
          end
        end
        ACQUIRE, LOCKED: begin
          if (silent) begin
            state_d    = NO_LINK;
            link_d     = 1'b0;
            valid_d    = 1'b0;
            match_d    = '0;
            pend_d     = SPEED_10M;
            ref_cnt_d  = '0;
            edge_cnt_d = '0;
            sil_d      = '0;
          end else if (term) begin
            if (state_q == LOCKED && cand == speed_q) begin
              match_d = '0;
            end else begin
              pend_d = cand;
              if (match_inc == MATCH_W'(HYST)) begin
                match_d = '0;
                state_d = LOCKED;
                speed_d = cand;
                mii_d   = (cand != SPEED_1000M);
                valid_d = 1'b1;
                chg_d   = 1'b1;
              end else begin
                match_d = match_inc;
              end
            end
          end
        end
        default: state_d = NO_LINK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sil_q      <= '0;
      match_q    <= '0;
      pend_q     <= SPEED_10M;
      state_q    <= NO_LINK;
      speed_q    <= SPEED_1000M;
      mii_q      <= 1'b0;
      valid_q    <= 1'b0;
      link_q     <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sil_q      <= sil_d;
      match_q    <= match_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      speed_q    <= speed_d;
      mii_q      <= mii_d;
      valid_q    <= valid_d;
      link_q     <= link_d;
      chg_q      <= chg_d;
    end
  end

  assign speed        = speed_q;
  assign mii_select   = mii_q;
  assign speed_valid  = valid_q;
  assign link_up      = link_q;
  assign speed_change = chg_q;

endmodule

// File: doc/eth_link_speed_detect.md
# eth_link_speed_detect

Parametrised RGMII link-speed detector. It samples an asynchronous toggle derived from the PHY receive clock in the `gtx_clk` domain and counts toggle edges against a reference window to classify 10M/100M/1000M. A classification is committed only after a configurable number of agreeing measurement windows. It reports link loss when the receive clock stops, and drives `speed`/`mii_select` for the RGMII PHY interface and the 1G MAC.

## Interface
- SYNC_STAGES, 3: synchroniser flops on `rx_toggle`; legal range ≥ 2.
- REF_CNT_W, 7: reference counter width; a window ends at ref count 2^REF_CNT_W−1.
- EDGE_CNT_W, 2: edge counter width; a measurement ends at edge count 2^EDGE_CNT_W−1.
- THRESH_100M, 32: if the ref count is ≥ this at edge overflow, classify 100M, else 1000M; must be < 2^REF_CNT_W.
- HYST, 2: consecutive identical candidates needed to commit; must be ≥ 1.
- NOLINK_WINDOWS, 16: consecutive edge-free ref windows that declare link loss; must be ≥ 1.
- clk  in  1  `gtx_clk`-domain clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_toggle  in  1  asynchronous toggle, rx_clk/8 square wave (rx prescaler MSB).
- enable  in  1  measurement enable.
- speed  out  2  00=10M, 01=100M, 10=1000M.
- mii_select  out  1  1 when `speed` != 10.
- speed_valid  out  1  a committed speed is current.
- link_up  out  1  receive clock is present.
- speed_change  out  1  one-cycle pulse on commit.

## Operation
- **Edge detection.** The SYNC_STAGES flop chain feeds one history flop. `edge` is asserted when the last sync flop differs from the history flop.
- **Counters.**
  - `ref_cnt` increments every enabled cycle.
  - `edge_cnt` increments on each enabled `edge`.
- **Window termination**, evaluated on the registered counts:
  - Edge overflow (`edge_cnt` all-ones): the candidate is 100M if `ref_cnt` ≥ THRESH_100M, else 1000M.
  - Ref overflow (`ref_cnt` all-ones) without edge overflow: the candidate is 10M.
  - Both overflows in the same cycle: edge overflow wins.
  - On either termination, both counters clear next cycle. An `edge` arriving in the termination cycle is discarded.
- **Silent counter.**
  - Clears on any `edge`.
  - Otherwise increments on each ref overflow in which `edge_cnt` == 0, saturating at NOLINK_WINDOWS.
  - Reaching NOLINK_WINDOWS is the `silent` condition.
- **Hysteresis** (`pend` candidate, `match` count of width clog2(HYST+1)):
  - A candidate equal to `pend` increments `match`.
  - Otherwise `pend` takes the candidate and `match` is set to 1.
  - When `match` reaches HYST, the candidate commits and `match` clears.
  - In LOCKED, a candidate equal to `speed` clears `match` and changes nothing.
- **FSM**, reset state NO_LINK:
  - NO_LINK → ACQUIRE on the first `edge`; `link_up`=1.
  - ACQUIRE → LOCKED on commit; `speed` is loaded, `speed_valid`=1, `speed_change` pulses even if the value is unchanged.
  - LOCKED stays LOCKED on commit of a different speed; `speed` is updated and `speed_change` pulses.
  - ACQUIRE or LOCKED → NO_LINK on `silent`; `link_up`=0, `speed_valid`=0, `speed` holds its last value, and `match`, `pend` and the counters clear.
- **enable=0.**
  - `ref_cnt`, `edge_cnt`, the silent counter and `match` are held at 0.
  - The synchroniser keeps running.
  - FSM state and all outputs hold.

## Timing
- **Reset values**, applied asynchronously on `rst_n`=0:
  - `speed`=2'b10, `mii_select`=0, `speed_valid`=0, `link_up`=0, `speed_change`=0.
  - All counters and sync flops = 0; FSM = NO_LINK.
- `edge` asserts SYNC_STAGES+1 cycles after an `rx_toggle` transition.
- All outputs are registered. `speed`/`mii_select`/`speed_valid`/`speed_change` update in the cycle after the terminating cycle of the committing window.
- `link_up` falls in the cycle after `silent` is reached.
- `speed_change` is exactly one cycle wide. Commits in back-to-back windows produce separate pulses.
- Reset deassertion is synchronised externally; the block needs no release sequencing.

## Structure
- Package `eth_speed_pkg`:
  - Speed encodings SPEED_10M/100M/1000M (2-bit).
  - FSM state typedef {NO_LINK, ACQUIRE, LOCKED}.
- Sub-module `sync_toggle_edge` (SYNC_STAGES parameter): synchroniser plus history flop, producing `edge`.
- Top level: counters, termination logic, hysteresis and FSM.

## Test plan
All scenarios use defaults, 8 ns `clk`, and `enable`=1 unless stated.
- **1000M acquire.** Toggle `rx_toggle` every 4 cycles after reset → windows end at ref≈12 → after the 2nd window: `speed`=10, `speed_valid`=1, `link_up`=1, `mii_select`=0, one `speed_change` pulse.
- **Switch to 100M.** From LOCKED 1000M, toggle every 20 cycles → first window: no change; second window: `speed`=01, `mii_select`=1, one pulse.
- **Hysteresis rejection.** Locked 100M; insert a single window with a 200-cycle toggle period, then resume a 20-cycle period → `speed` stays 01, no pulse.
- **10M and link loss.** Toggle every 200 cycles → `speed`=00 after 2 ref windows. Then stop toggling → after 16 edge-free windows (≈2048 cycles), `link_up`=0, `speed_valid`=0, `speed` holds 00.
- **Simultaneous overflow boundary.** Force the third edge so `edge_cnt` reaches 3 in the cycle `ref_cnt`=127 → candidate 100M, not 10M.
- **Mid-window async reset.** Pulse `rst_n` low with no `clk` edge while LOCKED 100M → outputs go to reset values immediately. After release, 1000M is reacquired as in scenario 1.
